// File: rtl/blinker_pkg.sv
// Shared types for the blinker bank: channel mode encoding, channel configuration
// record and the tap clamp helper used when a configuration is written.
package blinker_pkg;

  localparam int MAX_CNT_W = 32;
  localparam int TAP_IDX_W = 5;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PULSE = 2'd3
  } mode_e;

  // Offset is held zero-extended to the widest counter; tap is already clamped.
  typedef struct packed {
    mode_e                  mode;
    logic [TAP_IDX_W-1:0]   tap;
    logic [MAX_CNT_W-1:0]   offset;
  } chan_cfg_t;

  function automatic logic [TAP_IDX_W-1:0] clamp_tap(input logic [31:0] tap_raw,
                                                     input int cnt_w);
    if (tap_raw > 32'(cnt_w - 1)) return TAP_IDX_W'(cnt_w - 1);
    return tap_raw[TAP_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/blinker_channel.sv
// One blink channel: configuration register, phase-offset adder, tap select,
// rising-edge detector for PULSE and the registered output.
module blinker_channel
  import blinker_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  chan_cfg_t        wr_cfg,
  input  logic [CNT_W-1:0] count,
  output logic             out
);

  chan_cfg_t            cfg_q;
  logic                 written_q;
  logic                 prev_tap;
  logic                 out_q;
  logic                 tap_bit;
  logic                 out_d;
  logic [MAX_CNT_W-1:0] shifted;

  // Low CNT_W bits of the wide sum equal (count + offset) mod 2^CNT_W, and the
  // clamped tap never reaches above them.
  always_comb begin
    shifted = MAX_CNT_W'(count) + cfg_q.offset;
    tap_bit = shifted[cfg_q.tap];
  end

  // NOTE: out_d gets a default before the case so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    out_d = 1'b0;
    case (cfg_q.mode)
      MODE_OFF:   out_d = 1'b0;
      MODE_ON:    out_d = 1'b1;
      MODE_BLINK: out_d = tap_bit;
      MODE_PULSE: out_d = tap_bit & ~prev_tap & ~written_q;
      default:    out_d = 1'b0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '{mode: MODE_OFF, tap: '0, offset: '0};
      written_q <= 1'b0;
      prev_tap  <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      // prev_tap always follows the live tap bit, so after a reconfiguration it
      // reloads from the new settings while written_q masks the pulse.
      prev_tap  <= tap_bit;
      out_q     <= out_d;
      written_q <= wr_en;
      if (wr_en) cfg_q <= wr_cfg;
    end
  end

  assign out = out_q;

endmodule

// File: rtl/blinker_bank.sv
// Bank of NCH blink channels sharing one free-running counter, with a simple
// always-ready write port for per-channel mode, tap and phase offset.
module blinker_bank
  import blinker_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int CNT_W = 16,
  parameter  int TAP_W = 5,
  localparam int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [1:0]       wr_mode,
  input  logic [TAP_W-1:0] wr_tap,
  input  logic [CNT_W-1:0] wr_offset,
  output logic [CNT_W-1:0] count,
  output logic [NCH-1:0]   blink_out
);

  logic [CNT_W-1:0] count_q;
  logic             wr_fire;
  chan_cfg_t        wr_cfg;

  assign wr_ready = ~rst;
  assign wr_fire  = wr_valid & wr_ready;

  always_comb begin
    wr_cfg.mode   = mode_e'(wr_mode);
    wr_cfg.tap    = clamp_tap(32'(wr_tap), CNT_W);
    wr_cfg.offset = MAX_CNT_W'(wr_offset);
  end

  // sync outranks en; both are overridden by reset.
  always_ff @(posedge clk) begin
    if (rst)       count_q <= '0;
    else if (sync) count_q <= '0;
    else if (en)   count_q <= count_q + CNT_W'(1);
  end

  assign count = count_q;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic hit;
    // Channel numbers at or beyond NCH match no instance and are dropped.
    assign hit = wr_fire & (int'(wr_ch) == c);

    blinker_channel #(
      .CNT_W (CNT_W)
    ) u_channel (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (hit),
      .wr_cfg (wr_cfg),
      .count  (count_q),
      .out    (blink_out[c])
    );
  end

endmodule

// File: tb/tb_blinker_bank.sv
// Scoreboard bench for blinker_bank: a cycle-level reference model predicts every
// output, a monitor compares, and a narrow-counter instance covers tap clamping.
module tb_blinker_bank;

  logic        clk;
  logic        rst, en, sync, wr_valid, wr_ready;
  logic [1:0]  wr_ch, wr_mode;
  logic [4:0]  wr_tap;
  logic [15:0] wr_offset, count;
  logic [3:0]  blink_out;

  logic        s_rst, s_en, s_sync, s_wr_valid, s_wr_ready;
  logic [0:0]  s_wr_ch;
  logic [1:0]  s_wr_mode;
  logic [4:0]  s_wr_tap;
  logic [7:0]  s_wr_offset, s_count;
  logic [0:0]  s_blink;

  blinker_bank #(.NCH(4), .CNT_W(16), .TAP_W(5)) dut (
    .clk(clk), .rst(rst), .en(en), .sync(sync), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_ch(wr_ch), .wr_mode(wr_mode), .wr_tap(wr_tap),
    .wr_offset(wr_offset), .count(count), .blink_out(blink_out)
  );

  blinker_bank #(.NCH(1), .CNT_W(8), .TAP_W(5)) u_small (
    .clk(clk), .rst(s_rst), .en(s_en), .sync(s_sync), .wr_valid(s_wr_valid),
    .wr_ready(s_wr_ready), .wr_ch(s_wr_ch), .wr_mode(s_wr_mode), .wr_tap(s_wr_tap),
    .wr_offset(s_wr_offset), .count(s_count), .blink_out(s_blink)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned cnt;
    logic [3:0]  blink;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  bit   dir_phase = 0;

  // Reference state: counter value, per-channel settings and edge history.
  int unsigned m_cnt;
  int          m_mode[4];
  int          m_tap[4];
  int unsigned m_off[4];
  bit          m_prev[4];
  bit          m_wrote[4];
  logic [3:0]  m_blink;

  function automatic bit model_tap(input int c);
    int unsigned s, t;
    s = (m_cnt + m_off[c]) % 65536;
    t = (m_tap[c] > 15) ? 15 : m_tap[c];
    return bit'((s >> t) & 1);
  endfunction

  task automatic step(input bit r, input bit e, input bit s, input bit v, input int ch,
                      input int mode, input int tap, input int unsigned off);
    bit   tb[4];
    exp_t x;
    @(negedge clk);
    rst = r; en = e; sync = s; wr_valid = v;
    wr_ch = 2'(ch); wr_mode = 2'(mode); wr_tap = 5'(tap); wr_offset = 16'(off);
    for (int c = 0; c < 4; c++) tb[c] = model_tap(c);
    if (r) begin
      m_cnt = 0;
      for (int c = 0; c < 4; c++) begin
        m_mode[c] = 0; m_tap[c] = 0; m_off[c] = 0;
        m_prev[c] = 0; m_wrote[c] = 0; m_blink[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < 4; c++) begin
        case (m_mode[c])
          0: m_blink[c] = 1'b0;
          1: m_blink[c] = 1'b1;
          2: m_blink[c] = tb[c];
          default: m_blink[c] = tb[c] && !m_prev[c] && !m_wrote[c];
        endcase
        m_prev[c]  = tb[c];
        m_wrote[c] = v && (ch == c);
        if (v && ch == c) begin
          m_mode[c] = mode; m_tap[c] = tap; m_off[c] = off;
        end
      end
      if (s)      m_cnt = 0;
      else if (e) m_cnt = (m_cnt + 1) % 65536;
    end
    x.cnt = m_cnt; x.blink = m_blink; x.rdy = !r;
    exp_q.push_back(x);
  endtask

  // Monitor: one expected record per clock edge, compared just after the edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("count", 32'(count), mon_e.cnt);
      check("blink_out", 32'(blink_out), 32'(mon_e.blink));
      check("wr_ready", 32'(wr_ready), 32'(mon_e.rdy));
      if (dir_phase) begin
        case (count)
          16'd512, 16'd1025, 16'd1536: check("blink0_edge", 32'(blink_out[0]), 32'd0);
          16'd513, 16'd1024, 16'd1537: check("blink0_edge", 32'(blink_out[0]), 32'd1);
          default: ;
        endcase
        if (count >= 16'd2 && count < 16'd1600)
          check("pulse_tap2", 32'(blink_out[2]), 32'((count % 8) == 5));
      end
    end
  end

  initial begin
    rst = 1; en = 0; sync = 0; wr_valid = 0; wr_ch = 0; wr_mode = 0; wr_tap = 0; wr_offset = 0;
    s_rst = 1; s_en = 0; s_sync = 0; s_wr_valid = 0; s_wr_ch = 0; s_wr_mode = 0;
    s_wr_tap = 0; s_wr_offset = 0;

    // Reset with a write presented; it must be dropped.
    step(1, 1, 0, 1, 0, 1, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0);

    // Directed: two complementary BLINK channels, PULSE tap 2, PULSE tap 3.
    step(0, 0, 0, 1, 0, 2, 9, 0);
    step(0, 0, 0, 1, 1, 2, 9, 512);
    step(0, 0, 0, 1, 2, 3, 2, 0);
    step(0, 1, 1, 1, 3, 3, 3, 0);
    dir_phase = 1;
    repeat (1600) step(0, 1, 0, 0, 0, 0, 0, 0);
    dir_phase = 0;

    // Counter frozen: PULSE silent, BLINK holds; then resume.
    repeat (20) step(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (30) step(0, 1, 0, 0, 0, 0, 0, 0);

    // Retap PULSE channel 3 from 3 to 4 so it takes effect at count 8.
    step(0, 1, 1, 0, 0, 0, 0, 0);
    repeat (7) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 3, 3, 4, 0);
    repeat (30) step(0, 1, 0, 0, 0, 0, 0, 0);

    // One-cycle reset mid-BLINK, with sync and a write competing.
    step(0, 1, 0, 1, 0, 2, 3, 0);
    repeat (20) step(0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0, 1, 0, 0);
    repeat (10) step(0, 1, 0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    repeat (800) begin
      int tap;
      tap = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 31));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 3) == 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           tap, $urandom_range(0, 65535));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Narrow counter: tap 31 clamps to bit 7, offset 1.
    @(negedge clk);
    check("small_rdy_rst", 32'(s_wr_ready), 32'd0);
    check("small_cnt_rst", 32'(s_count), 32'd0);
    s_rst = 0; s_wr_valid = 1; s_wr_ch = 0; s_wr_mode = 2; s_wr_tap = 31; s_wr_offset = 1;
    @(negedge clk);
    s_wr_valid = 0; s_en = 1;
    check("small_rdy", 32'(s_wr_ready), 32'd1);
    for (int i = 0; i < 300; i++) begin
      if (s_count == 8'h7F) break;
      @(negedge clk);
    end
    s_en = 0;
    check("small_cnt_7f", 32'(s_count), 32'h7F);
    @(negedge clk);
    check("small_blink_80", 32'(s_blink), 32'd1);
    s_en = 1;
    for (int i = 0; i < 300; i++) begin
      if (s_count == 8'hFF) break;
      @(negedge clk);
    end
    s_en = 0;
    repeat (2) @(negedge clk);
    check("small_cnt_ff", 32'(s_count), 32'hFF);
    check("small_blink_wrap", 32'(s_blink), 32'd0);
    s_wr_valid = 1; s_wr_ch = 1; s_wr_mode = 1;
    @(negedge clk);
    s_wr_valid = 0;
    repeat (2) @(negedge clk);
    check("small_bad_ch", 32'(s_blink), 32'd0);
    s_sync = 1;
    @(negedge clk);
    s_sync = 0;
    check("small_sync", 32'(s_count), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
